// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter: channel select, double-dabble, saturation.
// Optional feature: define BCD_SIGNED_EN for two's-complement input handling.
module bcd_conv_seq #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4,
    parameter int CH     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CH-1:0]          sel,
    input  logic [CH*IN_W-1:0]     din,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   ovf,
    output logic                   neg
);

    localparam int SW = 4*DIGITS + IN_W;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_W - 1);
    localparam logic [31:0] LIMIT = 32'(10**DIGITS - 1);
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [SW-1:0]     sr;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     nxt;
    logic [CW-1:0]     cnt;
    logic [IN_W-1:0]   chosen;
    logic [IN_W-1:0]   mag;
    logic              mag_ovf;
    logic              ovf_q;

    // Lowest enabled channel wins; no channel enabled yields zero.
    always_comb begin
        chosen = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (sel[k]) chosen = din[k*IN_W +: IN_W];
        end
    end

`ifdef BCD_SIGNED_EN
    logic neg_q;

    // Magnitude of a two's-complement value; the most negative value
    // maps to 2^(IN_W-1), which still fits in IN_W unsigned bits.
    always_comb begin
        mag = chosen[IN_W-1] ? (~chosen + 1'b1) : chosen;
    end
`else
    // Unsigned input: the magnitude is the captured value itself.
    always_comb begin
        mag = chosen;
    end

    assign neg = 1'b0;
`endif

    // Overflow decided once at capture time from the magnitude.
    always_comb begin
        mag_ovf = 32'(mag) > LIMIT;
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[IN_W+4*i +: 4] >= 4'd5)
                adj[IN_W+4*i +: 4] = adj[IN_W+4*i +: 4] + 4'd3;
        end
        nxt = {adj[SW-2:0], 1'b0};
    end

    // Control FSM with registered busy/done and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg_q <= 1'b0;
            neg   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr    <= {{(4*DIGITS){1'b0}}, mag};
                        cnt   <= '0;
                        ovf_q <= mag_ovf;
`ifdef BCD_SIGNED_EN
                        neg_q <= chosen[IN_W-1];
`endif
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        bcd   <= ovf_q ? NINES : nxt[SW-1:IN_W];
                        ovf   <= ovf_q;
`ifdef BCD_SIGNED_EN
                        neg   <= neg_q;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Testbench for bcd_conv_seq: scoreboard of expected results vs done pulses.
// Reference model uses integer division for the decimal digits.
module tb_bcd_conv_seq;

    localparam int IN_W   = 14;
    localparam int DIGITS = 4;
    localparam int CH     = 3;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic        neg;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [CH-1:0]     sel = '0;
    logic [CH*IN_W-1:0] din = '0;
    logic              busy;
    logic              done;
    logic [15:0]       bcd;
    logic              ovf;
    logic              neg;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    bcd_conv_seq #(.IN_W(IN_W), .DIGITS(DIGITS), .CH(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sel   (sel),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf),
        .neg   (neg)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the expected one.
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, saturation above 9999.
    function automatic exp_t model(input logic [2:0] s,
                                   input logic [IN_W-1:0] a,
                                   input logic [IN_W-1:0] b,
                                   input logic [IN_W-1:0] c);
        exp_t e;
        int   v;
        int   m;
        int   p;
        if (s[0])      v = int'(a);
        else if (s[1]) v = int'(b);
        else if (s[2]) v = int'(c);
        else           v = 0;
        m = v;
        e.neg = 1'b0;
`ifdef BCD_SIGNED_EN
        if (v >= (1 << (IN_W - 1))) begin
            e.neg = 1'b1;
            m = (1 << IN_W) - v;
        end
`endif
        e.ovf = (m > 9999);
        e.bcd = 16'h0;
        if (e.ovf) begin
            e.bcd = 16'h9999;
        end else begin
            p = 1;
            for (int i = 0; i < DIGITS; i++) begin
                e.bcd[4*i +: 4] = 4'((m / p) % 10);
                p = p * 10;
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("bcd", int'(bcd), int'(e.bcd));
                check("ovf", int'(ovf), int'(e.ovf));
                check("neg", int'(neg), int'(e.neg));
            end
        end
    end

    // Issue one conversion; optionally check timing, a stray start,
    // or abort with reset at a given cycle.
    task automatic run(input logic [2:0] s,
                       input logic [IN_W-1:0] a,
                       input logic [IN_W-1:0] b,
                       input logic [IN_W-1:0] c,
                       input bit chk,
                       input int extra_cyc,
                       input int abort_cyc);
        exp_t e;
        bit   aborted;
        int   d0;
        aborted = 0;
        sel = s;
        din = {c, b, a};
        start = 1'b1;
        e = model(s, a, b, c);
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = n_done;
        sel = 3'($urandom);
        din = CH*IN_W'({$urandom, $urandom});
        for (int cyc = 1; cyc <= IN_W + 1; cyc++) begin
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_bcd", int'(bcd), 0);
                check("rst_ovf", int'(ovf), 0);
                check("rst_neg", int'(neg), 0);
                q.delete();
                aborted = 1;
                break;
            end
            if (chk) begin
                check("busy_cyc", int'(busy), 1);
                check("done_cyc", int'(done), int'(cyc == IN_W + 1));
            end
            start = (cyc == extra_cyc);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (aborted) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < IN_W + 4; i++) begin
                @(posedge clk);
                #1;
            end
            check("abort_no_done", n_done - d0, 0);
        end else begin
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done), 0);
            check("hold_bcd", int'(bcd), int'(e.bcd));
            check("one_done", n_done - d0, 1);
            check("queue_empty", q.size(), 0);
        end
    endtask

    initial begin
        logic [IN_W-1:0] r;
        rst_n = 1'b0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_bcd", int'(bcd), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_neg", int'(neg), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(3'b001, 14'd1234, 14'd0, 14'd0, 1, 0, 0);
        run(3'b110, 14'd0, 14'd9999, 14'd42, 1, 0, 0);
        run(3'b000, 14'd55, 14'd66, 14'd77, 1, 0, 0);
        run(3'b001, 14'd12000, 14'd0, 14'd0, 0, 0, 0);
        run(3'b001, 14'd7, 14'd0, 14'd0, 0, 0, 0);
        run(3'b001, 14'h3FF6, 14'd0, 14'd0, 0, 0, 0);
        run(3'b100, 14'd0, 14'd0, 14'd10000, 0, 0, 0);
        run(3'b010, 14'd0, 14'd16383, 14'd0, 0, 0, 0);
        run(3'b001, 14'h2000, 14'd0, 14'd0, 0, 0, 0);
        run(3'b001, 14'd8191, 14'd0, 14'd0, 0, 0, 0);
        run(3'b001, 14'd4321, 14'd0, 14'd0, 1, 5, 0);
        run(3'b001, 14'd5678, 14'd0, 14'd0, 0, 0, 8);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run(3'b010, 14'd0, 14'd2468, 14'd0, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            r = 14'($urandom_range(9990, 10010));
            if (i % 3 == 0)
                run(3'($urandom), r, 14'($urandom), 14'($urandom), 0, 0, 0);
            else
                run(3'($urandom), 14'($urandom), 14'($urandom),
                    14'($urandom), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
